gaussian_convolver: RTL and testbench

Streaming 2-D convolution engine that consumes the Q2.14 coefficient matrix produced by `gaussian_kernel` and applies it to a raster pixel stream. It captures the kernel when the generator's `done` is asserted, buffers SIZE-1 image lines, and forms a SIZE×SIZE sliding window. Each window is reduced by a 3-stage multiply / add / round pipeline into one filtered pixel on a valid/ready output toward the edge-detection stages.

---
 rtl/gaussian_convolver.sv | 215 +++++++++++++++++++++
 tb/tb_gaussian_convolver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_convolver.sv
// gaussian_convolver: streaming SIZE x SIZE convolution with a 3-stage mul/add/round pipeline.
// Define GAUSS_CONV_SAT_EN to clamp results to the pixel range; otherwise results wrap.
module gaussian_convolver #(
  parameter int SIZE            = 5,
  parameter int IMG_WIDTH       = 640,
  parameter int IMG_HEIGHT      = 480,
  parameter int PIXEL_BITS      = 8,
  parameter int COEFF_BITS      = 16,
  parameter int FRACTIONAL_BITS = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kernel_valid,
  input  logic signed [SIZE-1:0][SIZE-1:0][COEFF_BITS-1:0] kernel_matrix,
  input  logic s_valid,
  output logic s_ready,
  input  logic [PIXEL_BITS-1:0] s_pixel,
  input  logic s_sof,
  output logic m_valid,
  input  logic m_ready,
  output logic [PIXEL_BITS-1:0] m_pixel,
  output logic m_sof,
  output logic m_eol,
  output logic sof_err
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = PIXEL_BITS + COEFF_BITS + 1;
  localparam int AW = PW + $clog2(SIZE * SIZE);
  localparam logic signed [AW-1:0] HALF =
    AW'(1) <<< (FRACTIONAL_BITS - 1);

  typedef enum logic [1:0] {NO_KERNEL, READY, RUN} state_t;

  state_t state;
  logic kcap;
  logic [CW-1:0] col, pc;
  logic [RW-1:0] row, pr;
  logic signed [COEFF_BITS-1:0] coef [SIZE][SIZE];
  logic [PIXEL_BITS-1:0] lb [SIZE-1][IMG_WIDTH];
  logic [PIXEL_BITS-1:0] win [SIZE][SIZE];
  logic [PIXEL_BITS-1:0] colv [SIZE];
  logic signed [PW-1:0] prod [SIZE][SIZE];
  logic signed [AW-1:0] acc, sum, rnd;
  logic [PIXEL_BITS-1:0] res;
  logic stall, en, acc_px, take, launch;
  logic v0, v1, v2, s0, s1, s2, e0, e1, e2;

  assign stall   = m_valid & ~m_ready;
  assign en      = ~stall;
  assign s_ready = (state != NO_KERNEL) & ~stall;
  assign acc_px  = s_valid & s_ready;
  assign take    = acc_px & ((state == RUN) | s_sof);
  assign pc      = (state == RUN && !s_sof) ? col : '0;
  assign pr      = (state == RUN && !s_sof) ? row : '0;
  assign launch  = take && pr >= RW'(SIZE - 1)
                   && pc >= CW'(SIZE - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= NO_KERNEL;
      kcap    <= 1'b0;
      col     <= '0;
      row     <= '0;
      sof_err <= 1'b0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          coef[i][j] <= '0;
    end else begin
      sof_err <= 1'b0;
      unique case (state)
        NO_KERNEL: begin
          if (kernel_valid) begin
            kcap <= 1'b1;
            for (int i = 0; i < SIZE; i++)
              for (int j = 0; j < SIZE; j++)
                coef[i][j] <= $signed(kernel_matrix[i][j]);
          end
          if (kcap) state <= READY;
        end
        READY: begin
          if (kernel_valid)
            for (int i = 0; i < SIZE; i++)
              for (int j = 0; j < SIZE; j++)
                coef[i][j] <= $signed(kernel_matrix[i][j]);
          if (acc_px) begin
            if (s_sof) begin
              col   <= CW'(1);
              row   <= '0;
              state <= RUN;
            end else begin
              sof_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc_px) begin
            if (s_sof) begin
              sof_err <= 1'b1;
              col     <= CW'(1);
              row     <= '0;
            end else if (col == CW'(IMG_WIDTH - 1)) begin
              col <= '0;
              if (row == RW'(IMG_HEIGHT - 1)) begin
                row   <= '0;
                state <= READY;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: state <= NO_KERNEL;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < SIZE - 1; k++)
      colv[k] = lb[k][pc];
    colv[SIZE-1] = s_pixel;
  end

  // Each column is a small shift register: lb[0] holds the oldest line.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int k = 0; k < SIZE - 2; k++)
        lb[k][pc] <= lb[k+1][pc];
      lb[SIZE-2][pc] <= s_pixel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0 <= 1'b0;
      s0 <= 1'b0;
      e0 <= 1'b0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          win[i][j] <= '0;
    end else if (en) begin
      v0 <= launch;
      s0 <= launch && pr == RW'(SIZE - 1)
            && pc == CW'(SIZE - 1);
      e0 <= launch && pc == CW'(IMG_WIDTH - 1);
      if (take)
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE - 1; j++)
            win[i][j] <= win[i][j+1];
          win[i][SIZE-1] <= colv[i];
        end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        sum = sum + AW'(prod[i][j]);
  end

  assign rnd = (acc + HALF) >>> FRACTIONAL_BITS;

`ifdef GAUSS_CONV_SAT_EN
  localparam logic signed [AW-1:0] PMAX =
    AW'((1 << PIXEL_BITS) - 1);
  always_comb begin
    res = rnd[PIXEL_BITS-1:0];
    if (rnd < 0) res = '0;
    else if (rnd > PMAX) res = '1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^rnd[AW-1:PIXEL_BITS];
  assign res = rnd[PIXEL_BITS-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      e1 <= 1'b0;
      e2 <= 1'b0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_pixel <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          prod[i][j] <= '0;
    end else if (en) begin
      v1 <= v0;
      s1 <= s0;
      e1 <= e0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          prod[i][j] <= PW'($signed({1'b0, win[i][j]}))
                        * PW'(coef[i][j]);
      v2  <= v1;
      s2  <= s1;
      e2  <= e1;
      acc <= sum;
      m_valid <= v2;
      m_sof   <= v2 & s2;
      m_eol   <= v2 & e2;
      if (v2) m_pixel <= res;
    end
  end

endmodule

// File: tb/tb_gaussian_convolver.sv
// tb_gaussian_convolver: directed vectors on an 8x6 image.
// Covers identity, uniform, saturation, backpressure, framing and reset.
module tb_gaussian_convolver;
  localparam int SIZE = 5;
  localparam int W = 8;
  localparam int H = 6;
  localparam int PB = 8;
  localparam int CB = 16;
  localparam int FB = 14;

  typedef logic [SIZE-1:0][SIZE-1:0][CB-1:0] kmat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic kernel_valid = 1'b0;
  kmat_t km = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [PB-1:0] s_pixel = '0;
  logic s_sof = 1'b0;
  logic m_valid;
  logic m_ready = 1'b1;
  logic [PB-1:0] m_pixel;
  logic m_sof, m_eol, sof_err;

  int checks = 0;
  int errors = 0;
  int qpx[$];
  int qsof[$];
  int qeol[$];

  always #5 clk = ~clk;

  gaussian_convolver #(
    .SIZE(SIZE), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PIXEL_BITS(PB), .COEFF_BITS(CB),
    .FRACTIONAL_BITS(FB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .kernel_valid(kernel_valid), .kernel_matrix(km),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_pixel(s_pixel), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_pixel(m_pixel), .m_sof(m_sof), .m_eol(m_eol),
    .sof_err(sof_err)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transfers are sampled just before the rising edge.
  always @(negedge clk) begin
    #4;
    if (reset_n && m_valid && m_ready) begin
      qpx.push_back(int'(m_pixel));
      qsof.push_back(int'(m_sof));
      qeol.push_back(int'(m_eol));
    end
  end

  task automatic clear_q();
    qpx.delete();
    qsof.delete();
    qeol.delete();
  endtask

  task automatic send(input int px, input bit sof);
    int n = 0;
    s_valid = 1'b1;
    s_pixel = PB'(px);
    s_sof = sof;
    #1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic load(input kmat_t k);
    km = k;
    kernel_valid = 1'b1;
    @(negedge clk);
    kernel_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int n);
    int t = 0;
    while (qpx.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check(tag, qpx.size(), n);
  endtask

  task automatic check_identity(input string tag);
    int exp[8] = '{18, 19, 20, 21, 26, 27, 28, 29};
    drain({tag, "_cnt"}, 8);
    for (int i = 0; i < 8 && i < qpx.size(); i++) begin
      check({tag, "_px"}, qpx[i], exp[i]);
      check({tag, "_sof"}, qsof[i], (i == 0) ? 1 : 0);
      check({tag, "_eol"}, qeol[i], (i == 3 || i == 7) ? 1 : 0);
    end
    clear_q();
  endtask

  task automatic check_const(input string tag, input int v);
    drain({tag, "_cnt"}, 8);
    for (int i = 0; i < qpx.size(); i++)
      check({tag, "_px"}, qpx[i], v);
    clear_q();
  endtask

  kmat_t kid, kgau, ksat;
  int a[5] = '{7, 31, 52, 31, 7};
  int bad;
  int hold;
  int sat_exp;

  initial begin
    kid = '0;
    kid[2][2] = CB'(16384);
    ksat = '0;
    ksat[2][2] = CB'(32767);
    for (int m = 0; m < SIZE; m++)
      for (int n = 0; n < SIZE; n++)
        kgau[m][n] = CB'(a[m] * a[n]);
`ifdef GAUSS_CONV_SAT_EN
    sat_exp = 255;
`else
    sat_exp = 144;
`endif

    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_pixel", m_pixel, 0);
    check("rst_flags", {m_sof, m_eol, sof_err}, 0);
    reset_n = 1'b1;

    s_valid = 1'b1;
    s_sof = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_ready || sof_err) bad++;
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    check("no_kernel_gate", bad, 0);

    load(kid);
    check("kernel_ready", s_ready, 1);

    send(55, 1'b0);
    check("ready_sof_err", sof_err, 1);
    @(negedge clk);
    check("sof_err_pulse", sof_err, 0);

    for (int i = 0; i < W * H; i++) begin
      if (i == 10) begin
        kernel_valid = 1'b1;
        km = '0;
      end
      send(i, i == 0);
      kernel_valid = 1'b0;
    end
    check_identity("ident");

    fork
      for (int i = 0; i < W * H; i++) send(i, i == 0);
      begin
        int n = 0;
        bad = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_valid && n < 300);
        check("bp_started", m_valid, 1);
        m_ready = 1'b0;
        hold = int'(m_pixel);
        repeat (10) begin
          @(negedge clk);
          if (int'(m_pixel) != hold || s_ready || !m_valid) bad++;
        end
        m_ready = 1'b1;
        check("bp_stable", bad, 0);
      end
    join
    check_identity("bp");

    send(7, 1'b1);
    for (int i = 0; i < 19; i++) send(7, 1'b0);
    send(0, 1'b1);
    check("restart_sof_err", sof_err, 1);
    for (int i = 1; i < W * H; i++) send(i, 1'b0);
    check_identity("restart");

    load(ksat);
    for (int i = 0; i < W * H; i++) send(200, i == 0);
    check_const("sat", sat_exp);

    load(kgau);
    for (int i = 0; i < 36; i++) send(100, i == 0);
    send(100, 1'b0);
    check("lat_n0", m_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_n2", m_valid, 0);
    @(negedge clk);
    check("lat_n3", m_valid, 1);
    for (int i = 37; i < W * H; i++) send(100, 1'b0);
    check_const("uniform", 100);

    for (int i = 0; i < 38; i++) send(100, i == 0);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_pixel", m_pixel, 0);
    check("mid_rst_ready", s_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_sof = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_ready) bad++;
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    check("post_rst_gate", bad, 0);
    clear_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
